// File: rtl/urv_bus_pkg.sv
// -----------------------------------------------------------------------------
// urv_bus_pkg
//   Shared types and helpers for the urv data-memory bus fabric.
//   - bus_state_t       : fabric FSM states (IDLE / BUSY / ERR)
//   - DEFAULT_DW        : default data width
//   - DEFAULT_BE_W      : byte-enable width for the default data width
//   - ERR_RDATA_DEFAULT : load data returned on a bus error
//   - be_width()        : byte-enable width for a given data width (DW/8)
//   - idx_width()       : slot index width for N slots (at least 1 bit)
// -----------------------------------------------------------------------------
package urv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } bus_state_t;

    localparam int unsigned DEFAULT_DW        = 32;
    localparam int unsigned DEFAULT_BE_W      = DEFAULT_DW / 8;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // A single slot still needs a 1-bit index so vectors never collapse to zero width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_bus_addr_match.sv
// -----------------------------------------------------------------------------
// dm_bus_addr_match
//   Combinational address decoder. Slot i hits when
//   (addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]. When several slots
//   hit, the lowest index wins.
// Ports
//   addr  in   32     address to decode
//   hit   out  1      at least one slot matched
//   idx   out  IDX_W  index of the winning slot (0 when no hit)
// -----------------------------------------------------------------------------
module dm_bus_addr_match
    import urv_bus_pkg::*;
#(
    parameter int unsigned              N_SLAVES = 4,
    parameter logic [N_SLAVES*32-1:0]   SLV_BASE = '0,
    parameter logic [N_SLAVES*32-1:0]   SLV_MASK = '0,
    localparam int unsigned             IDX_W    = idx_width(N_SLAVES)
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves
        // a value unassigned and no latch is inferred.
        hit = 1'b0;
        idx = '0;
        // Scan from the top down so the last (lowest-index) match overwrites.
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dm_bus_fabric.sv
// -----------------------------------------------------------------------------
// dm_bus_fabric
//   Data-memory bus fabric between the urv_cpu data port and N peripheral
//   slots. A request in IDLE is latched and decoded; a hit drives a one-hot
//   slot select until that slot acks, a miss produces a one-cycle error
//   completion. Load data is registered; errors are flagged sticky with the
//   address of the first error since the last clear.
//
// Build option
//   DM_BUS_TIMEOUT_EN : when defined, a BUSY access with no ack for
//                       TIMEOUT_CYCLES cycles is aborted as a bus error.
//                       When undefined, BUSY waits for the ack indefinitely.
//
// Ports
//   clk_i        in   1           clock
//   rst_i        in   1           synchronous reset, active-high
//   dm_addr_i    in   32          CPU address
//   dm_data_s_i  in   DW          CPU store data
//   dm_be_i      in   DW/8        CPU byte select
//   dm_store_i   in   1           store request (wins over load)
//   dm_load_i    in   1           load request
//   dm_ready_o   out  1           fabric idle, request accepted this cycle
//   dm_done_o    out  1           one-cycle completion pulse
//   dm_data_l_o  out  DW          registered load data, valid with dm_done_o
//   sl_sel_o     out  N_SLAVES    one-hot slot select, held for the access
//   sl_addr_o    out  32          latched address
//   sl_data_o    out  DW          latched store data
//   sl_be_o      out  DW/8        latched byte enables
//   sl_we_o      out  1           latched write flag
//   sl_data_i    in   N*DW        packed slot read data
//   sl_ack_i     in   N_SLAVES    per-slot ack
//   err_o        out  1           sticky bus-error flag
//   err_addr_o   out  32          address of first error since last clear
//   err_clr_i    in   1           clears err_o (a simultaneous new error wins)
// -----------------------------------------------------------------------------
module dm_bus_fabric
    import urv_bus_pkg::*;
#(
    parameter int unsigned            N_SLAVES       = 4,
    parameter int unsigned            DW             = DEFAULT_DW,
    parameter logic [N_SLAVES*32-1:0] SLV_BASE       = '0,
    parameter logic [N_SLAVES*32-1:0] SLV_MASK       = '0,
    parameter int unsigned            TIMEOUT_CYCLES = 64,
    parameter logic [31:0]            ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               dm_addr_i,
    input  logic [DW-1:0]             dm_data_s_i,
    input  logic [be_width(DW)-1:0]   dm_be_i,
    input  logic                      dm_store_i,
    input  logic                      dm_load_i,
    output logic                      dm_ready_o,
    output logic                      dm_done_o,
    output logic [DW-1:0]             dm_data_l_o,
    output logic [N_SLAVES-1:0]       sl_sel_o,
    output logic [31:0]               sl_addr_o,
    output logic [DW-1:0]             sl_data_o,
    output logic [be_width(DW)-1:0]   sl_be_o,
    output logic                      sl_we_o,
    input  logic [N_SLAVES*DW-1:0]    sl_data_i,
    input  logic [N_SLAVES-1:0]       sl_ack_i,
    output logic                      err_o,
    output logic [31:0]               err_addr_o,
    input  logic                      err_clr_i
);

    localparam int unsigned IDX_W = idx_width(N_SLAVES);

    if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("dm_bus_fabric: N_SLAVES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dm_bus_fabric: TIMEOUT_CYCLES must be >= 2");
    end

    bus_state_t       state;
    logic [IDX_W-1:0] slot_q;      // slot of the access in flight
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic [DW-1:0]    rd_word;
    logic             ack_sel;

`ifdef DM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Decode the live CPU address; it is only consumed in IDLE.
    dm_bus_addr_match #(
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_match (
        .addr (dm_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the selected slot's ack and data matter; other slots are ignored.
    assign ack_sel = sl_ack_i[slot_q];
    assign rd_word = sl_data_i[slot_q*DW +: DW];

    // NOTE: state and every registered output are updated with non-blocking
    // assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            slot_q      <= '0;
            dm_ready_o  <= 1'b1;
            dm_done_o   <= 1'b0;
            dm_data_l_o <= '0;
            sl_sel_o    <= '0;
            sl_addr_o   <= '0;
            sl_data_o   <= '0;
            sl_be_o     <= '0;
            sl_we_o     <= 1'b0;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
`ifdef DM_BUS_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
        end else begin
            dm_done_o <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (dm_load_i || dm_store_i) begin
                        sl_addr_o  <= dm_addr_i;
                        sl_data_o  <= dm_data_s_i;
                        sl_be_o    <= dm_be_i;
                        sl_we_o    <= dm_store_i;
                        dm_ready_o <= 1'b0;
                        if (dec_hit) begin
                            slot_q   <= dec_idx;
                            sl_sel_o <= N_SLAVES'(1) << dec_idx;
                            state    <= ST_BUSY;
`ifdef DM_BUS_TIMEOUT_EN
                            busy_cnt <= '0;
`endif
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end

                ST_BUSY: begin
                    if (ack_sel) begin
                        if (!sl_we_o) begin
                            dm_data_l_o <= rd_word;
                        end
                        dm_done_o  <= 1'b1;
                        dm_ready_o <= 1'b1;
                        sl_sel_o   <= '0;
                        state      <= ST_IDLE;
                    end
`ifdef DM_BUS_TIMEOUT_EN
                    // Ack in the final allowed cycle still completes normally.
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        sl_sel_o <= '0;
                        state    <= ST_ERR;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end

                ST_ERR: begin
                    if (!sl_we_o) begin
                        dm_data_l_o <= DW'(ERR_RDATA);
                    end
                    dm_done_o  <= 1'b1;
                    dm_ready_o <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    sl_sel_o   <= '0;
                    dm_ready_o <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase

            // Sticky error: a new error beats a clear in the same cycle and,
            // in that case, also refreshes the captured address.
            if (state == ST_ERR) begin
                err_o <= 1'b1;
                if (!err_o || err_clr_i) begin
                    err_addr_o <= sl_addr_o;
                end
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_dm_bus_fabric
//   Self-checking bench for dm_bus_fabric. A transaction-level model predicts,
//   per cycle, what the fabric must show (ready, done, select, latched payload,
//   load data, error flag/address); a single negedge process compares.
//   Slaves ack their select after a per-transaction number of wait states;
//   unselected slots get random spurious acks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dm_bus_fabric;

    localparam int          NS   = 4;
    localparam int          TOUT = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [31:0] SBASE [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h1001_0000, 32'h0000_8000};
    localparam logic [31:0] SMASK [NS] = '{32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_8000};

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_be_i = '0;
    logic        dm_store_i = 1'b0;
    logic        dm_load_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic [127:0] sl_data_i = '0;
    logic [3:0]  sl_ack_i;
    logic        dm_ready_o, dm_done_o, sl_we_o, err_o;
    logic [31:0] dm_data_l_o, sl_addr_o, sl_data_o, err_addr_o;
    logic [3:0]  sl_sel_o, sl_be_o;

    dm_bus_fabric #(
        .N_SLAVES       (NS),
        .DW             (32),
        .SLV_BASE       ({SBASE[3], SBASE[2], SBASE[1], SBASE[0]}),
        .SLV_MASK       ({SMASK[3], SMASK[2], SMASK[1], SMASK[0]}),
        .TIMEOUT_CYCLES (TOUT),
        .ERR_RDATA      (ERRD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dm_addr_i   (dm_addr_i),
        .dm_data_s_i (dm_data_s_i),
        .dm_be_i     (dm_be_i),
        .dm_store_i  (dm_store_i),
        .dm_load_i   (dm_load_i),
        .dm_ready_o  (dm_ready_o),
        .dm_done_o   (dm_done_o),
        .dm_data_l_o (dm_data_l_o),
        .sl_sel_o    (sl_sel_o),
        .sl_addr_o   (sl_addr_o),
        .sl_data_o   (sl_data_o),
        .sl_be_o     (sl_be_o),
        .sl_we_o     (sl_we_o),
        .sl_data_i   (sl_data_i),
        .sl_ack_i    (sl_ack_i),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- slave behaviour ----------------
    int          lat_cur = 0;   // wait states of the slot being accessed
    int          wait_cnt = 0;  // cycles the current select has been high
    logic [3:0]  noise_ack = '0;
    logic [31:0] sd [NS];

    always @(posedge clk_i) wait_cnt <= (sl_sel_o != 0) ? wait_cnt + 1 : 0;
    assign sl_ack_i = (sl_sel_o & {4{wait_cnt >= lat_cur}}) | (noise_ack & ~sl_sel_o);

    // ---------------- model state and expectations ----------------
    logic [31:0] m_data_l = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_err_addr = '0;
    bit          done_carry = 0;
    bit          rand_clr_en = 0;

    bit          chk_en = 0;
    bit          exp_ready = 1, exp_done = 0, exp_busy = 0, exp_we = 0;
    logic [3:0]  exp_sel = '0, exp_be = '0;
    logic [31:0] exp_addr = '0, exp_wd = '0;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, req_cyc = 0, done_cyc = -1, sel_hi = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single compare process against the model, every cycle.
    always @(negedge clk_i) begin
        if (dm_done_o) done_cyc = cyc;
        if (sl_sel_o != 0) sel_hi++;
        if (chk_en) begin
            check("ready",    32'(dm_ready_o), 32'(exp_ready));
            check("done",     32'(dm_done_o),  32'(exp_done));
            check("sel",      32'(sl_sel_o),   32'(exp_sel));
            check("data_l",   dm_data_l_o,     m_data_l);
            check("err",      32'(err_o),      32'(m_err));
            check("err_addr", err_addr_o,      m_err_addr);
            if (exp_busy) begin
                check("sl_addr", sl_addr_o,      exp_addr);
                check("sl_data", sl_data_o,      exp_wd);
                check("sl_be",   32'(sl_be_o),   32'(exp_be));
                check("sl_we",   32'(sl_we_o),   32'(exp_we));
            end
        end
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & SMASK[i]) == SBASE[i]) return i;
        return -1;
    endfunction

    // Advance one clock; apply what the edge does to the error/data model.
    task automatic tick(input bit err_set, input logic [31:0] eaddr);
        bit clr;
        clr = err_clr_i;
        @(posedge clk_i);
        if (rst_i) begin
            m_err = 0; m_err_addr = '0; m_data_l = '0;
        end else if (err_set) begin
            if (!m_err || clr) m_err_addr = eaddr;
            m_err = 1;
        end else if (clr) begin
            m_err = 0;
        end
        #1;
        err_clr_i = rand_clr_en ? ($urandom_range(0, 7) == 0) : 1'b0;
        noise_ack = 4'($urandom);
    endtask

    task automatic idle_tick();
        dm_load_i = 0; dm_store_i = 0;
        exp_ready = 1; exp_sel = '0; exp_busy = 0; exp_done = done_carry;
        done_carry = 0;
        tick(0, '0);
    endtask

    // Idle cycle whose outputs the caller samples at the negedge, then tick(0,0).
    task automatic sample_cycle();
        dm_load_i = 0; dm_store_i = 0;
        exp_ready = 1; exp_sel = '0; exp_busy = 0; exp_done = 0;
        @(negedge clk_i);
    endtask

    task automatic run_txn(input logic [31:0] a, input bit st, input bit ld,
                           input logic [31:0] wd, input logic [3:0] be, input int lat,
                           input bit clr_in_err, input int rst_after);
        int  slot, busy;
        bit  acked;
        slot = decode(a);
        acked = 1;
        for (int i = 0; i < NS; i++) sd[i] = $urandom;
        sl_data_i = {sd[3], sd[2], sd[1], sd[0]};
        lat_cur = lat;
        // request cycle
        dm_addr_i = a; dm_data_s_i = wd; dm_be_i = be; dm_store_i = st; dm_load_i = ld;
        exp_ready = 1; exp_sel = '0; exp_busy = 0; exp_done = done_carry;
        req_cyc = cyc;
        tick(0, '0);
        done_carry = 0;
        if (slot >= 0) begin
            busy = lat + 1;
`ifdef DM_BUS_TIMEOUT_EN
            if (lat >= TOUT) begin busy = TOUT; acked = 0; end
`endif
            for (int k = 0; k < busy; k++) begin
                // The CPU side may wiggle; the fabric must ignore it while busy.
                dm_addr_i = $urandom; dm_data_s_i = $urandom; dm_be_i = 4'($urandom);
                dm_load_i = 1'($urandom); dm_store_i = 1'($urandom);
                exp_ready = 0; exp_sel = 4'(1 << slot); exp_done = 0; exp_busy = 1;
                exp_addr = a; exp_wd = wd; exp_be = be; exp_we = st;
                if (k == rst_after) begin
                    rst_i = 1;
                    tick(0, '0);
                    rst_i = 0;
                    dm_load_i = 0; dm_store_i = 0;
                    exp_busy = 0; done_carry = 0;
                    return;
                end
                tick(0, '0);
            end
            exp_busy = 0;
            if (acked) begin
                if (!st) m_data_l = sd[slot];
                done_carry = 1;
            end
        end
        if (slot < 0 || !acked) begin
            exp_ready = 0; exp_sel = '0; exp_done = 0; exp_busy = 0;
            if (clr_in_err) err_clr_i = 1;
            tick(1, a);
            if (!st) m_data_l = ERRD;
            done_carry = 1;
        end
        dm_load_i = 0; dm_store_i = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int lat, kind, sl;
        bit st, ld;

        // ---- reset ----
        rst_i = 1;
        repeat (3) tick(0, '0);
        @(negedge clk_i);
        check("rst_ready",    32'(dm_ready_o), 32'd1);
        check("rst_done",     32'(dm_done_o),  32'd0);
        check("rst_sel",      32'(sl_sel_o),   32'd0);
        check("rst_we",       32'(sl_we_o),    32'd0);
        check("rst_data_l",   dm_data_l_o,     32'd0);
        check("rst_err",      32'(err_o),      32'd0);
        check("rst_err_addr", err_addr_o,      32'd0);
        rst_i = 0;
        tick(0, '0);
        chk_en = 1;
        idle_tick();

        // ---- zero-wait load from slot 0 ----
        sel_hi = 0;
        run_txn(32'h0000_0010, 0, 1, '0, 4'hF, 0, 0, -1);
        sd[0] = 32'h1234_5678; // pin: rerun with fixed slot data
        idle_tick();
        sel_hi = 0;
        lat_cur = 0;
        sl_data_i = {sd[3], sd[2], 32'h1234_5678, sd[0]};
        sl_data_i[31:0] = 32'h1234_5678;
        dm_addr_i = 32'h0000_0010; dm_load_i = 1; dm_store_i = 0;
        exp_ready = 1; exp_sel = '0; exp_busy = 0; exp_done = 0;
        req_cyc = cyc;
        tick(0, '0);
        dm_load_i = 0;
        exp_ready = 0; exp_sel = 4'b0001; exp_busy = 0;
        tick(0, '0);
        m_data_l = 32'h1234_5678; done_carry = 1;
        idle_tick();
        check("lat_load0",    32'(done_cyc - req_cyc), 32'd2);
        check("sel_hi_load0", 32'(sel_hi),             32'd1);
        sample_cycle();
        check("load0_data",   dm_data_l_o, 32'h1234_5678);
        check("model_load0",  m_data_l,    32'h1234_5678);
        tick(0, '0);

        // ---- store to slot 2 with 3 wait states ----
        sel_hi = 0;
        run_txn(32'h1001_0004, 1, 0, 32'h0000_00A5, 4'b0001, 3, 0, -1);
        idle_tick();
        check("lat_store2",    32'(done_cyc - req_cyc), 32'd5);
        check("sel_hi_store2", 32'(sel_hi),             32'd4);
        sample_cycle();
        check("store2_keeps_data", dm_data_l_o, 32'h1234_5678);
        check("store2_we",         32'(sl_we_o), 32'd1);
        tick(0, '0);

        // ---- unmapped load ----
        run_txn(32'h2000_0000, 0, 1, '0, 4'hF, 0, 0, -1);
        idle_tick();
        check("lat_unmapped", 32'(done_cyc - req_cyc), 32'd2);
        sample_cycle();
        check("unmapped_data",     dm_data_l_o, 32'hDEAD_BEEF);
        check("unmapped_err",      32'(err_o),  32'd1);
        check("unmapped_err_addr", err_addr_o,  32'h2000_0000);
        tick(0, '0);

        // ---- second error keeps first address; clear; clear+error ----
        run_txn(32'h1000_0004, 0, 1, '0, 4'hF, 0, 0, -1);
        idle_tick();
        sample_cycle();
        check("second_err_addr", err_addr_o, 32'h2000_0000);
        tick(0, '0);
        err_clr_i = 1;
        idle_tick();
        sample_cycle();
        check("clr_err",      32'(err_o), 32'd0);
        check("clr_err_addr", err_addr_o, 32'h2000_0000);
        tick(0, '0);
        run_txn(32'h2000_0004, 1, 0, 32'h1, 4'hF, 0, 0, -1);
        idle_tick();
        run_txn(32'h3000_0000, 0, 1, '0, 4'hF, 0, 1, -1);
        idle_tick();
        sample_cycle();
        check("clr_set_err",      32'(err_o), 32'd1);
        check("clr_set_err_addr", err_addr_o, 32'h3000_0000);
        tick(0, '0);

        // ---- slot 1 that does not ack in time ----
        err_clr_i = 1;
        idle_tick();
        run_txn(32'h1000_0000, 0, 1, '0, 4'hF, 40, 0, -1);
        idle_tick();
        sample_cycle();
`ifdef DM_BUS_TIMEOUT_EN
        check("timeout_lat",      32'(done_cyc - req_cyc), 32'(TOUT + 2));
        check("timeout_err",      32'(err_o),              32'd1);
        check("timeout_err_addr", err_addr_o,              32'h1000_0000);
`else
        check("slow_ack_lat",     32'(done_cyc - req_cyc), 32'd42);
        check("slow_ack_err",     32'(err_o),              32'd0);
`endif
        tick(0, '0);

        // ---- reset in the middle of an access ----
        run_txn(32'h5000_0000, 0, 1, '0, 4'hF, 0, 0, -1); // make err_o = 1 first
        idle_tick();
        done_cyc = -1;
        run_txn(32'h1000_0000, 0, 1, '0, 4'hF, 40, 0, 3);
        sample_cycle();
        check("rst_mid_sel",   32'(sl_sel_o),   32'd0);
        check("rst_mid_ready", 32'(dm_ready_o), 32'd1);
        check("rst_mid_err",   32'(err_o),      32'd0);
        check("rst_mid_done",  32'(done_cyc),   32'hFFFF_FFFF);
        tick(0, '0);

        // ---- randomized traffic ----
        rand_clr_en = 1;
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1:    a = {16'h0000, 16'($urandom)};
                2:       a = 32'h1000_0000;
                3, 6:    a = {16'h1001, 16'($urandom)};
                4:       a = 32'h1000_0000 ^ (32'd1 << $urandom_range(0, 31));
                default: a = $urandom;
            endcase
            sl = decode(a);
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 12) : $urandom_range(0, 4);
            if (sl == 0) lat = 0;
            case ($urandom_range(0, 2))
                0:       begin ld = 1; st = 0; end
                1:       begin ld = 0; st = 1; end
                default: begin ld = 1; st = 1; end
            endcase
            run_txn(a, st, ld, $urandom, 4'($urandom), lat, 0, -1);
            if ($urandom_range(0, 1) == 1) idle_tick();
        end
        idle_tick();
        idle_tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
